// File: rtl/regs_dump.sv
// Register-file dump sequencer: walks the read port from the first to the last index
// and presents each captured word on a valid/ready output stream.
module regs_dump #(
    parameter int unsigned SKIP_ZERO = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FirstIdx = (SKIP_ZERO != 0) ? 5'd1 : 5'd0;
    localparam logic [4:0] LastIdx  = 5'(LAST_REG);

    typedef enum logic [1:0] {StIdle, StAddr, StHold, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  out_addr_q, out_addr_d;
    logic [31:0] out_data_q, out_data_d;

    // State, index and captured word registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 5'd0;
            out_addr_q <= 5'd0;
            out_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    // Sweep sequencing: ADDR samples the read port, HOLD waits for the consumer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = FirstIdx;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    out_addr_d = idx_q;
                    out_data_d = rd_data;
                    state_d    = StHold;
                end
            end
            StHold: begin
                // Abort takes priority over a same-cycle handshake.
                if (abort) begin
                    state_d = StIdle;
                end else if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StAddr;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded directly from registered state.
    always_comb begin
        rd_addr   = idx_q;
        out_addr  = out_addr_q;
        out_data  = out_data_q;
        out_valid = (state_q == StHold);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
    end

endmodule
